// File: rtl/tlb_access_ctrl.sv
// Translation front-end between MEM stage and TLB array; also sequences TLBWI/TLBWR and owns CP0 Random.
// Optional: define UNMAPPED_KSEG_EN to let kernel-mode kseg0/kseg1 bypass the TLB.
module tlb_access_ctrl #(
    parameter int TLB_LENGTH = 16,
    parameter int IDX_W      = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ReqValid,
    input  logic [31:0]      ReqAddr,
    input  logic             ReqWrite,
    input  logic             KernelMode,
    output logic             ReqReady,
    output logic             RespValid,
    output logic [31:0]      RespPAddr,
    output logic             RespExc,
    output logic [4:0]       RespExcCode,
    output logic [31:0]      RespBadVAddr,
    output logic [31:0]      TlbVAddr,
    input  logic [31:0]      TlbPAddr,
    input  logic             TlbHit,
    output logic             TlbWEn,
    output logic [IDX_W-1:0] TlbIndex,
    output logic [64:0]      TlbNewVal,
    input  logic             TlbwiReq,
    input  logic             TlbwrReq,
    input  logic [64:0]      EntryVal,
    input  logic [IDX_W-1:0] IndexReg,
    input  logic [IDX_W-1:0] WiredReg,
    output logic [IDX_W-1:0] RandomOut,
    output logic             WrDone
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_LENGTH - 1);

    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [1:0]       r_state;
    logic             r_write;
    logic [31:0]      r_tlb_vaddr;
    logic [31:0]      r_resp_paddr;
    logic             r_resp_exc;
    logic [4:0]       r_resp_code;
    logic [31:0]      r_resp_bad;
    logic [IDX_W-1:0] r_wr_index;
    logic [64:0]      r_wr_val;
    logic [IDX_W-1:0] r_random;

    logic             w_write_req;
    logic             w_addr_err;
    logic             w_unmapped;
    logic [IDX_W-1:0] w_random_nxt;

    assign w_write_req = TlbwiReq | TlbwrReq;
    assign w_addr_err  = ReqAddr[31] & ~KernelMode;

`ifdef UNMAPPED_KSEG_EN
    assign w_unmapped = KernelMode & (ReqAddr[31:30] == 2'b10);
`else
    assign w_unmapped = 1'b0;
`endif

    // Random walks down from the top to Wired, then wraps back to the top.
    always_comb begin
        w_random_nxt = r_random - 1'b1;
        if (WiredReg == RAND_TOP || r_random == WiredReg || r_random == '0)
            w_random_nxt = RAND_TOP;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_random <= RAND_TOP;
        else      r_random <= w_random_nxt;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_tlb_vaddr  <= '0;
            r_resp_paddr <= '0;
            r_resp_exc   <= 1'b0;
            r_resp_code  <= '0;
            r_resp_bad   <= '0;
            r_wr_index   <= '0;
            r_wr_val     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_write_req) begin
                        r_wr_index <= TlbwiReq ? IndexReg : r_random;
                        r_wr_val   <= EntryVal;
                        r_state    <= S_WRITE;
                    end else if (ReqValid) begin
                        r_write <= ReqWrite;
                        if (w_addr_err) begin
                            r_resp_exc   <= 1'b1;
                            r_resp_code  <= ReqWrite ? EXC_ADES : EXC_ADEL;
                            r_resp_bad   <= ReqAddr;
                            r_resp_paddr <= '0;
                            r_state      <= S_RESP;
                        end else if (w_unmapped) begin
                            r_resp_exc   <= 1'b0;
                            r_resp_code  <= '0;
                            r_resp_paddr <= {3'b000, ReqAddr[28:0]};
                            r_state      <= S_RESP;
                        end else begin
                            r_tlb_vaddr <= ReqAddr;
                            r_state     <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (TlbHit) begin
                        r_resp_exc   <= 1'b0;
                        r_resp_code  <= '0;
                        r_resp_paddr <= TlbPAddr;
                    end else begin
                        r_resp_exc   <= 1'b1;
                        r_resp_code  <= r_write ? EXC_TLBS : EXC_TLBL;
                        r_resp_bad   <= r_tlb_vaddr;
                        r_resp_paddr <= '0;
                    end
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated with Rst so nothing is advertised while reset is held.
    assign ReqReady     = Rst & (r_state == S_IDLE) & ~w_write_req;
    assign RespValid    = (r_state == S_RESP);
    assign RespPAddr    = r_resp_paddr;
    assign RespExc      = r_resp_exc;
    assign RespExcCode  = r_resp_code;
    assign RespBadVAddr = r_resp_bad;
    assign TlbVAddr     = r_tlb_vaddr;
    assign TlbWEn       = (r_state == S_WRITE);
    assign WrDone       = (r_state == S_WRITE);
    assign TlbIndex     = r_wr_index;
    assign TlbNewVal    = r_wr_val;
    assign RandomOut    = r_random;

endmodule

// File: tb/tb_tlb_access_ctrl.sv
// Directed self-checking bench for tlb_access_ctrl; expectations follow UNMAPPED_KSEG_EN.
module tb_tlb_access_ctrl;

    localparam int TLB_LENGTH = 16;
    localparam int IDX_W      = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             ReqValid, ReqWrite, KernelMode;
    logic [31:0]      ReqAddr;
    logic             ReqReady, RespValid, RespExc;
    logic [31:0]      RespPAddr, RespBadVAddr, TlbVAddr, TlbPAddr;
    logic [4:0]       RespExcCode;
    logic             TlbHit, TlbWEn, TlbwiReq, TlbwrReq, WrDone;
    logic [IDX_W-1:0] TlbIndex, IndexReg, WiredReg, RandomOut;
    logic [64:0]      TlbNewVal, EntryVal;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_tlbva = '0;

    tlb_access_ctrl #(.TLB_LENGTH(TLB_LENGTH), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqWrite(ReqWrite),
        .KernelMode(KernelMode), .ReqReady(ReqReady), .RespValid(RespValid), .RespPAddr(RespPAddr),
        .RespExc(RespExc), .RespExcCode(RespExcCode), .RespBadVAddr(RespBadVAddr),
        .TlbVAddr(TlbVAddr), .TlbPAddr(TlbPAddr), .TlbHit(TlbHit), .TlbWEn(TlbWEn),
        .TlbIndex(TlbIndex), .TlbNewVal(TlbNewVal), .TlbwiReq(TlbwiReq), .TlbwrReq(TlbwrReq),
        .EntryVal(EntryVal), .IndexReg(IndexReg), .WiredReg(WiredReg), .RandomOut(RandomOut),
        .WrDone(WrDone)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset(input logic [IDX_W-1:0] wired);
        Rst = 1'b0; ReqValid = 0; ReqAddr = '0; ReqWrite = 0; KernelMode = 0;
        TlbPAddr = '0; TlbHit = 0; TlbwiReq = 0; TlbwrReq = 0; EntryVal = '0;
        IndexReg = '0; WiredReg = wired;
        step();
        step();
        Rst = 1'b1;
        exp_tlbva = '0;
    endtask

    task automatic test_reset();
        apply_reset(4'd13);
        Rst = 1'b0;
        #1;
        checks++; if (RandomOut !== 4'd15) begin errors++; $display("FAIL reset_random got %0d exp 15", RandomOut); end
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL reset_respvalid got %b exp 0", RespValid); end
        checks++; if (TlbWEn !== 1'b0 || WrDone !== 1'b0) begin errors++; $display("FAIL reset_wen got %b/%b exp 0/0", TlbWEn, WrDone); end
        checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ReqReady); end
        checks++; if (RespPAddr !== 32'h0 || TlbVAddr !== 32'h0 || TlbIndex !== 4'h0) begin
            errors++; $display("FAIL reset_data got pa=%h va=%h idx=%h exp 0", RespPAddr, TlbVAddr, TlbIndex); end
        Rst = 1'b1;
        #1;
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", ReqReady); end
    endtask

    task automatic test_random();
        logic [IDX_W-1:0] seq [5];
        seq = '{4'd15, 4'd14, 4'd13, 4'd15, 4'd14};
        apply_reset(4'd13);
        for (int i = 0; i < 5; i++) begin
            checks++; if (RandomOut !== seq[i]) begin errors++; $display("FAIL random[%0d] got %0d exp %0d", i, RandomOut, seq[i]); end
            step();
        end
    endtask

    // Issue one request from IDLE and check latency and response fields.
    task automatic run_req(input string nm, input logic [31:0] addr, input logic wr, input logic km,
                           input logic hit, input logic [31:0] tpa, input int lat,
                           input logic eexc, input logic [4:0] ecode, input logic [31:0] epa);
        ReqValid = 1; ReqAddr = addr; ReqWrite = wr; KernelMode = km;
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL %s ready got %b exp 1", nm, ReqReady); end
        step();
        ReqValid = 0; ReqAddr = 32'hDEAD_BEEF;
        if (lat == 2) begin
            exp_tlbva = addr;
            checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL %s early_valid got %b exp 0", nm, RespValid); end
            checks++; if (TlbVAddr !== exp_tlbva) begin errors++; $display("FAIL %s tlbva got %h exp %h", nm, TlbVAddr, exp_tlbva); end
            TlbHit = hit; TlbPAddr = tpa;
            step();
            TlbHit = 0; TlbPAddr = '0;
        end else begin
            checks++; if (TlbVAddr !== exp_tlbva) begin errors++; $display("FAIL %s tlbva_untouched got %h exp %h", nm, TlbVAddr, exp_tlbva); end
        end
        checks++; if (RespValid !== 1'b1) begin errors++; $display("FAIL %s valid got %b exp 1", nm, RespValid); end
        checks++; if (RespExc !== eexc) begin errors++; $display("FAIL %s exc got %b exp %b", nm, RespExc, eexc); end
        checks++; if (RespPAddr !== epa) begin errors++; $display("FAIL %s paddr got %h exp %h", nm, RespPAddr, epa); end
        if (eexc) begin
            checks++; if (RespExcCode !== ecode) begin errors++; $display("FAIL %s code got %0d exp %0d", nm, RespExcCode, ecode); end
            checks++; if (RespBadVAddr !== addr) begin errors++; $display("FAIL %s badva got %h exp %h", nm, RespBadVAddr, addr); end
        end
        step();
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL %s valid_pulse got %b exp 0", nm, RespValid); end
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL %s back_idle got %b exp 1", nm, ReqReady); end
        checks++; if (RespPAddr !== epa) begin errors++; $display("FAIL %s paddr_hold got %h exp %h", nm, RespPAddr, epa); end
    endtask

    task automatic test_unmapped();
`ifdef UNMAPPED_KSEG_EN
        run_req("kseg0_load", 32'h8000_1234, 0, 1, 0, 32'h0, 1, 0, 5'd0, 32'h0000_1234);
        run_req("kseg1_store", 32'hA000_0004, 1, 1, 0, 32'h0, 1, 0, 5'd0, 32'h0000_0004);
`else
        run_req("kseg0_load", 32'h8000_1234, 0, 1, 1, 32'h0000_1234, 2, 0, 5'd0, 32'h0000_1234);
        run_req("kseg1_store", 32'hA000_0004, 1, 1, 1, 32'h0ABC_0004, 2, 0, 5'd0, 32'h0ABC_0004);
`endif
        run_req("kseg2_load", 32'hC000_0100, 0, 1, 1, 32'h0765_0100, 2, 0, 5'd0, 32'h0765_0100);
    endtask

    task automatic test_mapped();
        run_req("hit_store", 32'h0040_0010, 1, 0, 1, 32'h0123_4010, 2, 0, 5'd0, 32'h0123_4010);
        run_req("miss_load", 32'h0040_0010, 0, 0, 0, 32'h0, 2, 1, 5'd2, 32'h0);
        run_req("miss_store", 32'h0040_0010, 1, 0, 0, 32'h0, 2, 1, 5'd3, 32'h0);
    endtask

    task automatic test_addr_err();
        run_req("ades", 32'h9000_0000, 1, 0, 0, 32'h0, 1, 1, 5'd5, 32'h0);
        run_req("adel", 32'hFFFF_FFFC, 0, 0, 1, 32'h1111_1111, 1, 1, 5'd4, 32'h0);
    endtask

    task automatic test_write_priority();
        ReqValid = 1; ReqAddr = 32'h0040_0020; ReqWrite = 0; KernelMode = 0;
        TlbwiReq = 1; TlbwrReq = 1; IndexReg = 4'd5; EntryVal = 65'h1_2345_6789_ABCD_EF01;
        #1;
        checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL wr_ready_block got %b exp 0", ReqReady); end
        step();
        TlbwiReq = 0; TlbwrReq = 0; EntryVal = '0; IndexReg = 4'd9;
        checks++; if (TlbWEn !== 1'b1 || WrDone !== 1'b1) begin errors++; $display("FAIL wi_wen got %b/%b exp 1/1", TlbWEn, WrDone); end
        checks++; if (TlbIndex !== 4'd5) begin errors++; $display("FAIL wi_index got %0d exp 5", TlbIndex); end
        checks++; if (TlbNewVal !== 65'h1_2345_6789_ABCD_EF01) begin errors++; $display("FAIL wi_val got %h exp 123456789abcdef01", TlbNewVal); end
        checks++; if (ReqReady !== 1'b0 || RespValid !== 1'b0) begin errors++; $display("FAIL wi_busy got rdy=%b vld=%b exp 0/0", ReqReady, RespValid); end
        step();
        checks++; if (TlbWEn !== 1'b0 || WrDone !== 1'b0) begin errors++; $display("FAIL wi_oneshot got %b/%b exp 0/0", TlbWEn, WrDone); end
        checks++; if (TlbVAddr !== exp_tlbva) begin errors++; $display("FAIL wi_no_accept got %h exp %h", TlbVAddr, exp_tlbva); end
        run_req("after_write", 32'h0040_0020, 0, 0, 1, 32'h0222_0020, 2, 0, 5'd0, 32'h0222_0020);
    endtask

    task automatic test_tlbwr();
        apply_reset(4'd0);
        step();
        step();
        TlbwrReq = 1; EntryVal = 65'h0_0000_0000_0000_0ABC;
        step();
        TlbwrReq = 0;
        checks++; if (TlbWEn !== 1'b1) begin errors++; $display("FAIL wr_wen got %b exp 1", TlbWEn); end
        checks++; if (TlbIndex !== 4'd13) begin errors++; $display("FAIL wr_index got %0d exp 13", TlbIndex); end
        step();
    endtask

    task automatic test_reset_mid_lookup();
        ReqValid = 1; ReqAddr = 32'h0040_0030; ReqWrite = 0; KernelMode = 0;
        step();
        ReqValid = 0;
        checks++; if (RespValid !== 1'b0 || TlbVAddr !== 32'h0040_0030) begin
            errors++; $display("FAIL lookup_entry got vld=%b va=%h exp 0/00400030", RespValid, TlbVAddr); end
        TlbHit = 1; TlbPAddr = 32'h0333_0030;
        Rst = 0;
        #1;
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL rst_lookup_valid got %b exp 0", RespValid); end
        checks++; if (RandomOut !== 4'd15) begin errors++; $display("FAIL rst_lookup_random got %0d exp 15", RandomOut); end
        step();
        Rst = 1; TlbHit = 0;
        step();
        checks++; if (RespValid !== 1'b0 || TlbWEn !== 1'b0) begin errors++; $display("FAIL rst_after got vld=%b wen=%b exp 0/0", RespValid, TlbWEn); end
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL rst_after_ready got %b exp 1", ReqReady); end
    endtask

    initial begin
        test_reset();
        test_random();
        test_unmapped();
        test_mapped();
        test_addr_err();
        test_write_priority();
        test_tlbwr();
        test_reset_mid_lookup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_access_ctrl.md
Name: tlb_access_ctrl

Overview:
- Translation front-end between the MEM stage and the TLB array.
- Accepts one load/store translation request at a time and classifies the address as unmapped kseg, address error or mapped.
- Mapped addresses are driven to the TLB; the result comes back as a registered response with MIPS exception codes.
- Also sequences TLBWI/TLBWR writes into the TLB and owns the CP0 Random counter.

Parameters:
- TLB_LENGTH, 16, number of TLB entries.
- IDX_W, 4, index width; must equal log2(TLB_LENGTH).

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- ReqValid  in  1  MEM stage translation request
- ReqAddr  in  32  virtual address
- ReqWrite  in  1  1 = store, 0 = load
- KernelMode  in  1  CP0 status: kernel mode
- ReqReady  out  1  request can be accepted this cycle
- RespValid  out  1  one-cycle response strobe
- RespPAddr  out  32  physical address
- RespExc  out  1  exception flag
- RespExcCode  out  5  2=TLBL, 3=TLBS, 4=AdEL, 5=AdES
- RespBadVAddr  out  32  faulting virtual address
- TlbVAddr  out  32  lookup address to TLB
- TlbPAddr  in  32  TLB translated address
- TlbHit  in  1  TLB hit
- TlbWEn  out  1  TLB write enable
- TlbIndex  out  IDX_W  TLB write index
- TlbNewVal  out  65  entry written to TLB
- TlbwiReq  in  1  TLBWI pulse
- TlbwrReq  in  1  TLBWR pulse
- EntryVal  in  65  entry assembled from EntryHi/Lo0/Lo1/PageMask
- IndexReg  in  IDX_W  CP0 Index
- WiredReg  in  IDX_W  CP0 Wired
- RandomOut  out  IDX_W  CP0 Random
- WrDone  out  1  write completed

Behaviour:
- Reset (Rst=0, async): state IDLE; RandomOut=TLB_LENGTH-1; every other output 0.
- States: IDLE, LOOKUP, RESP, WRITE.
- ReqReady=1 only in IDLE with TlbwiReq=0 and TlbwrReq=0.
- IDLE, write priority:
  - TlbwiReq or TlbwrReq present: latch EntryVal and index, go WRITE.
  - Index is IndexReg for TLBWI, current RandomOut for TLBWR.
  - TLBWI wins if both asserted.
  - Any simultaneous ReqValid is not accepted (ReqReady=0).
- IDLE, request accept (ReqValid && ReqReady): latch ReqAddr, ReqWrite; classify:
  - ReqAddr[31]=1 and KernelMode=0: address error. RespExc=1, code 4 (load) or 5 (store), RespBadVAddr=addr, RespPAddr=0. Go RESP.
  - ReqAddr[31:30]=2'b10 and KernelMode=1: unmapped. RespPAddr={3'b000, addr[28:0]}, RespExc=0. Go RESP.
  - Otherwise: TlbVAddr=addr (held stable through LOOKUP). Go LOOKUP.
- LOOKUP: sample TlbHit/TlbPAddr at the end of the cycle.
  - Hit: RespPAddr=TlbPAddr, RespExc=0.
  - Miss: RespExc=1, code 2 (load) or 3 (store), RespBadVAddr=addr, RespPAddr=0.
  - Go RESP.
- RESP: RespValid=1 for exactly one cycle, then IDLE. Resp* data holds until the next response.
- Latency from the accept edge to RespValid:
  - unmapped/address error: 1 cycle;
  - mapped: 2 cycles.
- WRITE (one cycle): TlbWEn=1, TlbIndex/TlbNewVal from latched values, WrDone=1. Then IDLE.
- Random counter, updated every clock in every state:
  - if RandomOut==WiredReg, or WiredReg>TLB_LENGTH-1 is impossible by width, next value is TLB_LENGTH-1;
  - else decrement by 1;
  - if WiredReg==TLB_LENGTH-1, hold at TLB_LENGTH-1.
  - TLBWR uses the value present in the IDLE acceptance cycle.
- Reset asserted mid-LOOKUP/WRITE: returns to IDLE immediately; no RespValid or TlbWEn is emitted afterwards.
- Back-to-back: a new request can be accepted in the cycle after RESP or WRITE, i.e. when back in IDLE.

Optional Feature:
- Macro: UNMAPPED_KSEG_EN.
- Defined: kseg0/kseg1 bypass the TLB as above (1-cycle latency).
- Undefined: every kernel-mode address is mapped through LOOKUP (2-cycle latency).
  - User-mode address errors are unchanged.

Test Plan:
- KernelMode=1, load 0x8000_1234 (macro on) -> RespValid one cycle after accept, RespPAddr=0x0000_1234, RespExc=0, TlbVAddr untouched.
- KernelMode=0, store 0x0040_0010, TlbHit=1, TlbPAddr=0x0123_4010 -> RespValid two cycles after accept, RespPAddr=0x0123_4010, RespExc=0.
- KernelMode=0, load 0x0040_0010, TlbHit=0 -> RespExc=1, RespExcCode=2, RespBadVAddr=0x0040_0010; same as store -> code 3.
- KernelMode=0, store 0x9000_0000 -> RespExc=1, code 5, BadVAddr=0x9000_0000, no TLB lookup.
- WiredReg=13, TLB_LENGTH=16, run from reset -> RandomOut sequence 15,14,13,15,14,...
- TlbwiReq and TlbwrReq together with IndexReg=5 and ReqValid=1 -> next cycle TlbWEn=1, TlbIndex=5, WrDone=1; request accepted only after return to IDLE. Assert Rst=0 during LOOKUP -> RespValid stays 0 and RandomOut=15.
